rtc_bus_scheduler: RTL and testbench
====================================

Name: rtc_bus_scheduler

Overview:
- Owns the single RTC address/data bus and decides which command sequencer drives it: initialisation, write (user time/date/timer set) or read (periodic refresh of the register bank).
- Grants one sequencer at a time and produces the per-transaction phase count (0..42) that all sequencers decode to time address, data and register enables.
- Sits between the top-level FSM / user-input logic and the init, write and read sequencers, in front of the RTC bus driver and mux.

Parameters:
- CYCLE_LEN, 43, clock cycles per bus transaction (phase counter runs 0..CYCLE_LEN-1).
- N_INIT, 2, transactions in the init sequence.
- N_WRITE, 10, transactions in the write sequence (F0 command plus 9 addresses).
- N_READ, 11, transactions in the read sequence (F0, 0x20–0x26, 0x41–0x43).
- READ_PERIOD, 1_000_000, clock cycles between automatic read requests.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset: asynchronous, active-low (asserted when 0).
- req_init, in, 1, single-cycle init request pulse.
- req_escr, in, 1, single-cycle write request pulse.
- req_leer, in, 1, single-cycle manual read request pulse.
- auto_rd_en, in, 1, enables the periodic read timer.
- enable_init, out, 1, grant level to the init sequencer.
- enable_escr, out, 1, grant level to the write sequencer.
- enable_leer, out, 1, grant level to the read sequencer.
- cont_fase, out, 6, phase within the current transaction.
- cont_trans, out, 4, transaction index within the granted sequence.
- sel_bus, out, 2, bus mux select: 00 none, 01 init, 10 write, 11 read.
- done_init, out, 1, one-cycle pulse when the init sequence finishes.
- done_escr, out, 1, one-cycle pulse when the write sequence finishes.
- done_leer, out, 1, one-cycle pulse when the read sequence finishes.
- busy, out, 1, high whenever the state is not IDLE.

Behaviour:
- Reset (rst=0, async): all outputs are 0, the state is IDLE, the pending bits are 0, the refresh timer is 0. Reset mid-transaction aborts immediately with no done pulse.
- Pending latches: pend_x is set on the cycle after req_x=1 and cleared on the done_x cycle. A request for the sequence currently granted re-sets pend_x after its done pulse, so that sequence is served again.
- Refresh timer:
  - Counts only while auto_rd_en=1; it is cleared when auto_rd_en=0.
  - At READ_PERIOD-1 it wraps to 0 and sets pend_leer.
  - If pend_leer is already set, the new request merges with it and is not queued.
- States: IDLE, G_INIT, G_ESCR, G_LEER, GAP.
- IDLE selects by fixed priority init > escr > leer among the pending bits.
  - One cycle after a pending bit is set, the state is G_x, enable_x=1, sel_bus is set, and cont_fase=0, cont_trans=0.
  - There is no preemption: a higher-priority request waits for the current sequence to end.
- G_x:
  - cont_fase increments every cycle.
  - At CYCLE_LEN-1, cont_fase wraps to 0 and cont_trans increments.
  - At cont_fase=CYCLE_LEN-1 with cont_trans=N_x-1: done_x=1 for that cycle, pend_x clears, next state is GAP.
- GAP: lasts one cycle. All enables are 0, sel_bus=00, and both counters are 0. Next state is IDLE.
  - This guarantees bus turnaround between sequences.
  - Back-to-back sequences start 2 cycles after done.
- Simultaneous events:
  - Requests arriving in the same cycle are latched together and resolved by priority.
  - A refresh tick during G_LEER sets pend_leer again, giving one more read.
- Exactly one enable_x is high at a time. sel_bus is consistent with enable_x in every cycle.
- All outputs are registered.

Decomposition:
- Shared package rtc_pkg holds:
  - the state encoding;
  - the sel_bus codes (SEL_NONE/INIT/ESCR/LEER);
  - CYCLE_LEN and the N_* constants, also used by the sequencers;
  - phase constants used by the sequencers: FASE_ADDR=7, FASE_EN_ON=27, FASE_EN_OFF=33, FASE_END=42.
- Sub-module rtc_refresh_timer (timer plus tick output) is natural. The phase and transaction counters stay in the top module.

Test Plan:
- Reset, then req_leer pulse at cycle 10 → enable_leer=1 and sel_bus=11 from cycle 12; done_leer at cycle 12+11·43-1=484; busy=0 at cycle 486.
- req_leer and req_escr in the same cycle → write granted first; done_escr after 430 cycles; read starts 2 cycles after done_escr.
- req_init during G_LEER (cont_trans=3) → read completes all 11 transactions untouched, then init runs 2 transactions (86 cycles).
- READ_PERIOD=100, auto_rd_en=1, idle → pend_leer at tick 100; read repeats every max(100, 473+2) cycles; auto_rd_en=0 stops further reads.
- rst=0 at cont_fase=20 of G_ESCR → all outputs 0 asynchronously; no done_escr; after release, busy stays 0 with no pending requests.
- Scoreboard over all tests → sel_bus matches the one-hot enables every cycle; cont_fase never exceeds 42; cont_trans never reaches N_x.

Source files
------------

// File: rtl/rtc_bus_scheduler_pkg.sv
// Shared definitions for the RTC bus scheduler and the init/write/read sequencers:
// state encoding, bus-select codes, sequence lengths and phase landmarks.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_G_INIT,
    ST_G_ESCR,
    ST_G_LEER,
    ST_GAP
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_INIT = 2'b01;
  localparam logic [1:0] SEL_ESCR = 2'b10;
  localparam logic [1:0] SEL_LEER = 2'b11;

  localparam int CYCLE_LEN = 43;
  localparam int N_INIT    = 2;
  localparam int N_WRITE   = 10;
  localparam int N_READ    = 11;

  // Phase landmarks decoded by the sequencers within each 43-cycle transaction
  localparam int FASE_ADDR   = 7;
  localparam int FASE_EN_ON  = 27;
  localparam int FASE_EN_OFF = 33;
  localparam int FASE_END    = 42;

  // Fixed priority: init > write > read
  function automatic state_t arbitrate(input logic [2:0] pend);
    if (pend[2])      return ST_G_INIT;
    else if (pend[1]) return ST_G_ESCR;
    else if (pend[0]) return ST_G_LEER;
    else              return ST_IDLE;
  endfunction

  // Grant vector ordered {init, escr, leer}
  function automatic logic [2:0] grant_vec(input state_t s);
    case (s)
      ST_G_INIT: return 3'b100;
      ST_G_ESCR: return 3'b010;
      ST_G_LEER: return 3'b001;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      ST_G_INIT: return SEL_INIT;
      ST_G_ESCR: return SEL_ESCR;
      ST_G_LEER: return SEL_LEER;
      default:   return SEL_NONE;
    endcase
  endfunction

  function automatic logic [3:0] last_trans(input state_t s);
    case (s)
      ST_G_INIT: return 4'(N_INIT - 1);
      ST_G_ESCR: return 4'(N_WRITE - 1);
      ST_G_LEER: return 4'(N_READ - 1);
      default:   return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_scheduler_if.sv
// Request/grant bundle between the top-level control logic, the scheduler
// and the sequencers that decode its phase and transaction counters.
interface rtc_bus_scheduler_if;
  logic       req_init;
  logic       req_escr;
  logic       req_leer;
  logic       auto_rd_en;
  logic       enable_init;
  logic       enable_escr;
  logic       enable_leer;
  logic [5:0] cont_fase;
  logic [3:0] cont_trans;
  logic [1:0] sel_bus;
  logic       done_init;
  logic       done_escr;
  logic       done_leer;
  logic       busy;

  modport master (
    output req_init, req_escr, req_leer, auto_rd_en,
    input  enable_init, enable_escr, enable_leer, cont_fase, cont_trans,
           sel_bus, done_init, done_escr, done_leer, busy
  );

  modport slave (
    input  req_init, req_escr, req_leer, auto_rd_en,
    output enable_init, enable_escr, enable_leer, cont_fase, cont_trans,
           sel_bus, done_init, done_escr, done_leer, busy
  );
endinterface

// File: rtl/rtc_bus_scheduler_refresh_timer.sv
// Free-running refresh timer: while enabled, pulses o_tick once every READ_PERIOD
// cycles to request a register-bank read; held at zero while disabled.
module rtc_refresh_timer #(
  parameter int READ_PERIOD = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);
  localparam int CNT_W = (READ_PERIOD > 2) ? $clog2(READ_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(READ_PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!i_en || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates the single RTC bus between the init, write and read sequencers and
// generates the phase/transaction counters they decode. All outputs registered.
module rtc_bus_scheduler
  import rtc_pkg::*;
#(
  parameter int READ_PERIOD = 1_000_000
) (
  input logic                clk,
  input logic                rst,
  rtc_bus_scheduler_if.slave bus
);
  localparam logic [5:0] FASE_LAST = 6'(CYCLE_LEN - 1);

  state_t     r_state, w_state_nxt;
  logic [5:0] r_fase, w_fase_nxt;
  logic [3:0] r_trans, w_trans_nxt, w_last_trans;
  logic [2:0] r_pend, r_again, r_done, w_done_nxt;
  logic [2:0] w_set, w_granted, r_enable;
  logic [1:0] r_sel;
  logic       r_busy;
  logic       w_tick;

  rtc_refresh_timer #(.READ_PERIOD(READ_PERIOD)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_en   (bus.auto_rd_en),
    .o_tick (w_tick)
  );

  // Vectors ordered {init, escr, leer}; a refresh tick counts as a read request
  assign w_set        = {bus.req_init, bus.req_escr, bus.req_leer | w_tick};
  assign w_granted    = grant_vec(r_state);
  assign w_last_trans = last_trans(r_state);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_fase_nxt  = '0;
    w_trans_nxt = '0;
    w_done_nxt  = '0;
    case (r_state)
      ST_G_INIT, ST_G_ESCR, ST_G_LEER: begin
        if (r_fase == FASE_LAST) begin
          if (r_trans == w_last_trans) w_state_nxt = ST_GAP;
          else                         w_trans_nxt = r_trans + 4'd1;
        end else begin
          w_fase_nxt  = r_fase + 6'd1;
          w_trans_nxt = r_trans;
          if (r_fase == FASE_LAST - 6'd1 && r_trans == w_last_trans)
            w_done_nxt = w_granted;
        end
      end
      // GAP arbitrates too, so a queued sequence starts two cycles after done
      default: w_state_nxt = arbitrate(r_pend);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_fase   <= '0;
      r_trans  <= '0;
      r_done   <= '0;
      r_enable <= '0;
      r_sel    <= SEL_NONE;
      r_busy   <= 1'b0;
      r_pend   <= '0;
      r_again  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_fase   <= w_fase_nxt;
      r_trans  <= w_trans_nxt;
      r_done   <= w_done_nxt;
      r_enable <= grant_vec(w_state_nxt);
      r_sel    <= sel_of(w_state_nxt);
      r_busy   <= (w_state_nxt != ST_IDLE);
      // A request for the running sequence is remembered and re-arms it at done
      r_pend   <= (r_pend & ~r_done) | (r_again & r_done) | w_set;
      r_again  <= (r_again | (w_set & w_granted)) & ~r_done;
    end
  end

  assign {bus.enable_init, bus.enable_escr, bus.enable_leer} = r_enable;
  assign {bus.done_init, bus.done_escr, bus.done_leer}       = r_done;
  assign bus.cont_fase  = r_fase;
  assign bus.cont_trans = r_trans;
  assign bus.sel_bus    = r_sel;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Self-checking bench for rtc_bus_scheduler: directed vector table, hand-written
// corner sequences, and randomized traffic against an arithmetic reference model.
module tb_rtc_bus_scheduler;
  import rtc_pkg::*;

  localparam int RP = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rtc_bus_scheduler_if bus_if ();

  rtc_bus_scheduler #(.READ_PERIOD(RP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct packed {
    logic [2:0] en;     // {init, escr, leer}
    logic [1:0] sel;
    logic [5:0] fase;
    logic [3:0] trans;
    logic [2:0] done;   // {init, escr, leer}
    logic       busy;
  } obs_t;

  typedef struct {
    int         cyc;
    logic [2:0] req;    // {init, escr, leer} pulsed in this cycle
    bit         chk;
    logic [1:0] sel;
    int         fase;
    int         trans;
    logic [2:0] done;
    logic       busy;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t0       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc - t0);
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.en    = {bus_if.enable_init, bus_if.enable_escr, bus_if.enable_leer};
    o.sel   = bus_if.sel_bus;
    o.fase  = bus_if.cont_fase;
    o.trans = bus_if.cont_trans;
    o.done  = {bus_if.done_init, bus_if.done_escr, bus_if.done_leer};
    o.busy  = bus_if.busy;
    return o;
  endfunction

  function automatic logic [2:0] en_of(input logic [1:0] s);
    case (s)
      2'b01:   return 3'b100;
      2'b10:   return 3'b010;
      2'b11:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int n_of(input int s);
    case (s)
      0:       return N_INIT;
      1:       return N_WRITE;
      default: return N_READ;
    endcase
  endfunction

  // Cycle-level invariants: one-hot grants, sel consistent, counters in range
  function automatic logic inv_ok(input obs_t o);
    logic [1:0] s;
    case (o.en)
      3'b000:  s = 2'd0;
      3'b100:  s = 2'd1;
      3'b010:  s = 2'd2;
      3'b001:  s = 2'd3;
      default: return 1'b0;
    endcase
    if (o.sel != s) return 1'b0;
    if (o.fase > 6'd42) return 1'b0;
    if ((o.done & ~o.en) != 3'b000) return 1'b0;
    if (s == 2'd0) return (o.trans == 4'd0) && (o.fase == 6'd0);
    return int'(o.trans) < n_of(int'(s) - 1);
  endfunction

  // Reference model: a sequence is a span of N*CYCLE_LEN cycles from its start;
  // phase and index follow from elapsed time. owed[] holds requests not yet started.
  int       m_mode;   // 0 idle, 1 granted, 2 gap
  int       m_cur;    // 0 init, 1 escr, 2 leer
  int       m_start;
  int       m_cyc;
  int       m_timer;
  bit [2:0] m_owed;
  obs_t     m_exp;

  function automatic obs_t model_view();
    obs_t o = '0;
    int   e;
    if (m_mode == 1) begin
      e       = m_cyc - m_start;
      o.en    = 3'b100 >> m_cur;
      o.sel   = 2'(m_cur + 1);
      o.fase  = 6'(e % CYCLE_LEN);
      o.trans = 4'(e / CYCLE_LEN);
      if (e == n_of(m_cur) * CYCLE_LEN - 1) o.done = 3'b100 >> m_cur;
      o.busy  = 1'b1;
    end else if (m_mode == 2) begin
      o.busy = 1'b1;
    end
    return o;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_cur   = 0;
    m_start = 0;
    m_cyc   = 0;
    m_timer = 0;
    m_owed  = '0;
    m_exp   = '0;
  endtask

  task automatic model_step();
    bit [2:0] set;
    int       granted = -1;
    set[0] = bus_if.req_init;
    set[1] = bus_if.req_escr;
    set[2] = bus_if.req_leer | (bus_if.auto_rd_en && m_timer == RP - 1);
    m_timer = bus_if.auto_rd_en ? ((m_timer == RP - 1) ? 0 : m_timer + 1) : 0;
    if (m_mode == 1) begin
      if (m_cyc - m_start == n_of(m_cur) * CYCLE_LEN - 1) m_mode = 2;
    end else begin
      m_mode = 0;
      for (int i = 0; i < 3; i++) if (m_owed[i] && granted < 0) granted = i;
      if (granted >= 0) begin
        m_mode         = 1;
        m_cur          = granted;
        m_start        = m_cyc + 1;
        m_owed[granted] = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) if (set[i] && i != granted) m_owed[i] = 1'b1;
    m_cyc++;
    m_exp = model_view();
  endtask

  always @(negedge clk) begin
    obs_t o;
    o = observe();
    if (!rst) begin
      model_reset();
      check("reset_outputs", 32'(o), 32'd0);
    end else begin
      check("model", 32'(o), 32'(m_exp));
      check("invariants", {31'd0, inv_ok(o)}, 32'd1);
      model_step();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reqs(input logic [2:0] r);
    {bus_if.req_init, bus_if.req_escr, bus_if.req_leer} = r;
  endtask

  function automatic vec_t v(input int c, input logic [2:0] r, input bit k, input logic [1:0] s,
                             input int f, input int t, input logic [2:0] d, input logic b);
    vec_t x;
    x.cyc = c; x.req = r; x.chk = k; x.sel = s;
    x.fase = f; x.trans = t; x.done = d; x.busy = b;
    return x;
  endfunction

  vec_t vecs[$];

  initial begin
    int   waited;
    int   cnt;
    obs_t want;

    // Single read, write+read collision, init arriving mid-read
    vecs.push_back(v(  10, 3'b001, 1, 2'b00,  0,  0, 3'b000, 0));
    vecs.push_back(v(  11, 3'b000, 1, 2'b00,  0,  0, 3'b000, 0));
    vecs.push_back(v(  12, 3'b000, 1, 2'b11,  0,  0, 3'b000, 1));
    vecs.push_back(v(  55, 3'b000, 1, 2'b11,  0,  1, 3'b000, 1));
    vecs.push_back(v( 484, 3'b000, 1, 2'b11, 42, 10, 3'b001, 1));
    vecs.push_back(v( 485, 3'b000, 1, 2'b00,  0,  0, 3'b000, 1));
    vecs.push_back(v( 486, 3'b000, 1, 2'b00,  0,  0, 3'b000, 0));
    vecs.push_back(v( 500, 3'b011, 0, 2'b00,  0,  0, 3'b000, 0));
    vecs.push_back(v( 502, 3'b000, 1, 2'b10,  0,  0, 3'b000, 1));
    vecs.push_back(v( 931, 3'b000, 1, 2'b10, 42,  9, 3'b010, 1));
    vecs.push_back(v( 932, 3'b000, 1, 2'b00,  0,  0, 3'b000, 1));
    vecs.push_back(v( 933, 3'b000, 1, 2'b11,  0,  0, 3'b000, 1));
    vecs.push_back(v(1405, 3'b000, 1, 2'b11, 42, 10, 3'b001, 1));
    vecs.push_back(v(1407, 3'b000, 1, 2'b00,  0,  0, 3'b000, 0));
    vecs.push_back(v(1500, 3'b001, 0, 2'b00,  0,  0, 3'b000, 0));
    vecs.push_back(v(1502, 3'b000, 1, 2'b11,  0,  0, 3'b000, 1));
    vecs.push_back(v(1635, 3'b100, 1, 2'b11,  4,  3, 3'b000, 1));
    vecs.push_back(v(1700, 3'b000, 1, 2'b11, 26,  4, 3'b000, 1));
    vecs.push_back(v(1974, 3'b000, 1, 2'b11, 42, 10, 3'b001, 1));
    vecs.push_back(v(1975, 3'b000, 1, 2'b00,  0,  0, 3'b000, 1));
    vecs.push_back(v(1976, 3'b000, 1, 2'b01,  0,  0, 3'b000, 1));
    vecs.push_back(v(2061, 3'b000, 1, 2'b01, 42,  1, 3'b100, 1));
    vecs.push_back(v(2063, 3'b000, 1, 2'b00,  0,  0, 3'b000, 0));

    set_reqs(3'b000);
    bus_if.auto_rd_en = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    t0  = cyc;

    foreach (vecs[i]) begin
      while (cyc - t0 < vecs[i].cyc) begin
        step();
        set_reqs(3'b000);
      end
      set_reqs(vecs[i].req);
      if (vecs[i].chk) begin
        @(negedge clk);
        want = {en_of(vecs[i].sel), vecs[i].sel, 6'(vecs[i].fase), 4'(vecs[i].trans),
                vecs[i].done, vecs[i].busy};
        check($sformatf("vec%0d", i), 32'(observe()), 32'(want));
      end
    end
    step();
    set_reqs(3'b000);
    repeat (5) step();

    // Periodic refresh: first read 101 cycles after enabling, then stop cleanly
    bus_if.auto_rd_en = 1'b1;
    waited = 0;
    while (bus_if.sel_bus != 2'b11 && waited < 200) begin
      step();
      waited++;
    end
    check("auto_first_read_latency", waited, 101);
    repeat (1500) step();
    bus_if.auto_rd_en = 1'b0;
    waited = 0;
    while (bus_if.busy !== 1'b0 && waited < 2000) begin
      step();
      waited++;
    end
    check("auto_drains", {31'd0, bus_if.busy}, 32'd0);
    cnt = 0;
    repeat (300) begin
      step();
      if (bus_if.busy) cnt++;
    end
    check("auto_off_quiet", cnt, 0);

    // Asynchronous reset in the middle of a write transaction
    set_reqs(3'b010);
    step();
    set_reqs(3'b000);
    waited = 0;
    while (bus_if.sel_bus != 2'b10 && waited < 10) begin
      step();
      waited++;
    end
    repeat (20) step();
    check("pre_reset_fase", 32'(bus_if.cont_fase), 32'd20);
    #1 rst = 1'b0;
    #1 check("async_reset", 32'(observe()), 32'd0);
    repeat (3) step();
    rst = 1'b1;
    cnt = 0;
    repeat (60) begin
      step();
      if (bus_if.busy || bus_if.done_escr) cnt++;
    end
    check("post_reset_idle", cnt, 0);

    // Randomized traffic, checked cycle by cycle against the model
    repeat (20000) begin
      step();
      set_reqs({$urandom_range(0, 399) == 0, $urandom_range(0, 399) == 0,
                $urandom_range(0, 399) == 0});
      if ($urandom_range(0, 2999) == 0) bus_if.auto_rd_en = ~bus_if.auto_rd_en;
    end
    set_reqs(3'b000);
    bus_if.auto_rd_en = 1'b0;
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
